// File: rtl/cache_storage_assoc.sv
// Set-associative tag/data storage with per-set age-ordered LRU, zero-latency lookup
// and a flush sequencer that invalidates one set per cycle.
module cache_storage_assoc #(
   parameter int DATA_W          = 32,
   parameter int INDEX_W         = 5,
   parameter int TAG_W           = 6,
   parameter int WORDS_PER_BLOCK = 8,
   parameter int WAYS            = 2,
   localparam int SETS           = 1 << INDEX_W,
   localparam int WSEL_W         = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1,
   localparam int WAY_W          = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [INDEX_W-1:0] index,
   input  logic [WSEL_W-1:0] word_sel,
   input  logic [TAG_W-1:0]  tag_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic [WAY_W-1:0]  way_sel,
   input  logic              we_data,
   input  logic              we_tag,
   input  logic              set_dirty,
   input  logic              touch,
   input  logic              flush,
   output logic              hit,
   output logic [WAY_W-1:0]  hit_way,
   output logic [WAY_W-1:0]  victim_way,
   output logic [TAG_W-1:0]  victim_tag,
   output logic              victim_dirty,
   output logic [DATA_W-1:0] data_out,
   output logic              busy,
   output logic              flush_done
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   localparam logic [WAY_W-1:0]   AGE_MAX  = WAY_W'(WAYS - 1);
   localparam logic [WAY_W-1:0]   WAY_MASK = WAY_W'(WAYS - 1);
   localparam logic [INDEX_W-1:0] LAST_SET = INDEX_W'(SETS - 1);

   logic [TAG_W-1:0]  tag_q  [SETS][WAYS];
   logic [WAY_W-1:0]  age_q  [SETS][WAYS];
   logic [WAYS-1:0]   valid_q [SETS];
   logic [WAYS-1:0]   dirty_q [SETS];
   logic [DATA_W-1:0] data_q [SETS][WAYS][WORDS_PER_BLOCK];

   state_t             state_q;
   logic [INDEX_W-1:0] cnt_q;
   logic               busy_q;
   logic               flush_done_q;

   logic [WAY_W-1:0] way_eff_s;
   logic [WAY_W-1:0] old_age_s;
   logic [WAY_W-1:0] age_d [WAYS];
   logic [WAYS-1:0]  match_s;
   logic [WAY_W-1:0] hit_way_s;
   logic [WAY_W-1:0] lru_way_s;
   logic [WAY_W-1:0] inv_way_s;
   logic             hit_s;
   logic [WAY_W-1:0] victim_way_s;
   logic [WAY_W-1:0] out_way_s;

   // A direct-mapped build has only way 0, so out-of-range selects fold onto it.
   assign way_eff_s = way_sel & WAY_MASK;

   // Next ages for the addressed set when way_eff_s becomes most recently used.
   always_comb begin
      old_age_s = age_q[index][way_eff_s];
      for (int w = 0; w < WAYS; w++) begin
         if (WAY_W'(w) == way_eff_s) begin
            age_d[w] = '0;
         end else if (age_q[index][w] < old_age_s) begin
            age_d[w] = age_q[index][w] + WAY_W'(1);
         end else begin
            age_d[w] = age_q[index][w];
         end
      end
   end

   // Tag compare plus lowest-match, lowest-invalid and oldest-way selection.
   always_comb begin
      match_s   = '0;
      hit_way_s = '0;
      lru_way_s = '0;
      inv_way_s = '0;
      for (int w = 0; w < WAYS; w++) begin
         match_s[w] = valid_q[index][w] && (tag_q[index][w] == tag_in);
         lru_way_s  = (age_q[index][w] == AGE_MAX) ? WAY_W'(w) : lru_way_s;
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         hit_way_s = match_s[w] ? WAY_W'(w) : hit_way_s;
         inv_way_s = (!valid_q[index][w]) ? WAY_W'(w) : inv_way_s;
      end
   end

   assign hit_s        = (|match_s) & ~busy_q;
   assign victim_way_s = (&valid_q[index]) ? lru_way_s : inv_way_s;
   assign out_way_s    = hit_s ? hit_way_s : victim_way_s;

   assign hit          = hit_s;
   assign hit_way      = hit_s ? hit_way_s : '0;
   assign victim_way   = victim_way_s;
   assign victim_tag   = tag_q[index][victim_way_s];
   assign victim_dirty = valid_q[index][victim_way_s] & dirty_q[index][victim_way_s];
   assign data_out     = data_q[index][out_way_s][word_sel];
   assign busy         = busy_q;
   assign flush_done   = flush_done_q;

   // Flush sequencer: flush_done is raised on the edge that loads the last set number.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
         flush_done_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (flush) begin
                  state_q      <= ST_FLUSH;
                  cnt_q        <= '0;
                  busy_q       <= 1'b1;
                  flush_done_q <= 1'b0;
               end else begin
                  cnt_q        <= '0;
                  busy_q       <= 1'b0;
                  flush_done_q <= 1'b0;
               end
            end
            ST_FLUSH: begin
               if (cnt_q == LAST_SET) begin
                  state_q      <= ST_IDLE;
                  cnt_q        <= '0;
                  busy_q       <= 1'b0;
                  flush_done_q <= 1'b0;
               end else begin
                  cnt_q        <= cnt_q + INDEX_W'(1);
                  busy_q       <= 1'b1;
                  flush_done_q <= ((cnt_q + INDEX_W'(1)) == LAST_SET);
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               cnt_q        <= '0;
               busy_q       <= 1'b0;
               flush_done_q <= 1'b0;
            end
         endcase
      end
   end

   // Tag, valid, dirty and age state: reset, per-set flush clearing, or host updates.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               tag_q[s][w] <= '0;
               age_q[s][w] <= WAY_W'(w);
            end
         end
      end else if (busy_q) begin
         valid_q[cnt_q] <= '0;
         dirty_q[cnt_q] <= '0;
         for (int w = 0; w < WAYS; w++) begin
            age_q[cnt_q][w] <= WAY_W'(w);
         end
      end else begin
         if (we_tag) begin
            tag_q[index][way_eff_s]   <= tag_in;
            valid_q[index][way_eff_s] <= 1'b1;
            dirty_q[index][way_eff_s] <= set_dirty;
         end else if (set_dirty && valid_q[index][way_eff_s]) begin
            dirty_q[index][way_eff_s] <= 1'b1;
         end
         if (touch) begin
            for (int w = 0; w < WAYS; w++) begin
               age_q[index][w] <= age_d[w];
            end
         end
      end
   end

   // Data words are left uninitialised by reset; only host writes outside a flush land.
   always_ff @(posedge clk) begin
      if (we_data && !busy_q) begin
         data_q[index][way_eff_s][word_sel] <= data_in;
      end
   end

endmodule

// File: doc/cache_storage_assoc.md
CACHE_STORAGE_ASSOC -- requirements
Module: cache_storage_assoc

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits.
REQ-002 Parameter INDEX_W, default 5, set index width; SETS = 2^INDEX_W.
REQ-003 Parameter TAG_W, default 6, tag width in bits.
REQ-004 Parameter WORDS_PER_BLOCK, default 8, words per line, power of two; WSEL_W = clog2(WORDS_PER_BLOCK).
REQ-005 Parameter WAYS, default 2, associativity, one of 1, 2 or 4; WAY_W = max(1, clog2(WAYS)).
REQ-006 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1, synchronous active-high reset.
REQ-008 Port index, input, INDEX_W, set address.
REQ-009 Port word_sel, input, WSEL_W, word within line.
REQ-010 Port tag_in, input, TAG_W, lookup tag and fill tag.
REQ-011 Port data_in, input, DATA_W, write data.
REQ-012 Port way_sel, input, WAY_W, target way for we_data, we_tag, set_dirty and touch.
REQ-013 Port we_data, input, 1, write data_in to word (index, way_sel, word_sel).
REQ-014 Port we_tag, input, 1, fill tag/valid/dirty of (index, way_sel).
REQ-015 Port set_dirty, input, 1, mark (index, way_sel) dirty.
REQ-016 Port touch, input, 1, make way_sel most-recently-used in set index.
REQ-017 Port flush, input, 1, one-cycle request to invalidate the whole cache.
REQ-018 Port hit, output, 1, valid tag match in set index.
REQ-019 Port hit_way, output, WAY_W, matching way (0 when no hit).
REQ-020 Port victim_way, output, WAY_W, replacement candidate for set index.
REQ-021 Port victim_tag, output, TAG_W, tag stored in victim_way.
REQ-022 Port victim_dirty, output, 1, victim_way is valid and dirty.
REQ-023 Port data_out, output, DATA_W, word (index, hit_way, word_sel) on hit, else (index, victim_way, word_sel).
REQ-024 Port busy, output, 1, flush sequence in progress.
REQ-025 Port flush_done, output, 1, one-cycle pulse at the end of flush.

Function
REQ-026 Lookup outputs (hit, hit_way, victim_*, data_out) SHALL be combinational from index/word_sel/tag_in and current state, with zero-cycle latency.
REQ-027 On multiple matching ways, hit_way SHALL be the lowest-numbered way.
REQ-028 victim_way SHALL be the lowest-numbered invalid way, else the way with age WAYS-1.
REQ-029 Each set SHALL keep one WAY_W-bit age per way, always a permutation of 0..WAYS-1; age 0 = MRU.
REQ-030 touch SHALL set age of way_sel to 0 and increment every way whose age was below the old age of way_sel; other ages are unchanged.
REQ-031 we_tag SHALL write tag<=tag_in, valid<=1, dirty<=set_dirty for (index, way_sel).
REQ-032 set_dirty without we_tag SHALL set dirty<=1 only when that way is valid.
REQ-033 we_data, we_tag, set_dirty and touch in the same cycle SHALL all take effect.
REQ-034 Writes SHALL be visible on lookup outputs the cycle after the edge.
REQ-035 FSM states: IDLE and FLUSH; flush in IDLE -> FLUSH with line counter 0.
REQ-036 In FLUSH, each cycle SHALL clear valid and dirty of all ways of set counter, reset its ages to way number, then increment counter.
REQ-037 When counter = SETS-1, FSM SHALL return to IDLE and pulse flush_done for that cycle; a flush takes exactly SETS cycles.
REQ-038 busy SHALL be 1 exactly while in FLUSH.
REQ-039 While busy, hit SHALL be 0 and we_data, we_tag, set_dirty, touch and flush SHALL be ignored.
REQ-040 WAYS=1 SHALL behave as direct-mapped: victim_way and hit_way are 0 and touch has no effect.

Reset
REQ-041 On rst, all valid and dirty bits SHALL clear, every tag SHALL clear to 0, every set's ages SHALL equal way number, and the FSM SHALL return to IDLE with counter 0.
REQ-042 After rst, busy=0, flush_done=0 and hit=0; the data array is not reset.
REQ-043 rst during FLUSH SHALL abort the sequence without a flush_done pulse.

Verification
REQ-044 After rst, WAYS=2: index=3, tag_in=5 -> hit=0, victim_way=0, victim_dirty=0.
REQ-045 Fill way0 (tag 5) and way1 (tag 9) at index 3, writing word 2 = 0xA5A5A5A5 in way1, then look up tag 9 word 2 -> hit=1, hit_way=1, data_out=0xA5A5A5A5.
REQ-046 At index 3, touch way0 then way1 -> victim_way=0; touch way0 -> victim_way=1.
REQ-047 set_dirty on way1 index 3, touch way0, look up tag 7 -> hit=0, victim_way=1, victim_tag=9, victim_dirty=1.
REQ-048 Fill index 3, pulse flush -> busy=1 for 32 cycles, flush_done on the 32nd cycle, writes ignored meanwhile, then tag 5 -> hit=0.
REQ-049 Assert rst 10 cycles into a flush -> busy=0 next cycle, no flush_done, all lines invalid.
